// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/exec/mem/wb,
// drives datapath selects and strobes, detects faults, counts cycles.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int PERF_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  pc_en,
  output logic [1:0]            pc_source,
  output logic                  reg_write,
  output logic [1:0]            reg_dst,
  output logic [1:0]            mem_to_reg,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic                  ext_op,
  output logic [4:0]            alu_ctr,
  output logic [3:0]            state,
  output logic                  illegal,
  output logic                  bus_err,
  output logic [PERF_CNT_W-1:0] cycle_cnt,
  output logic [PERF_CNT_W-1:0] instret_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_FAULT    = 4'd12
  } state_t;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd2;
  localparam logic [4:0] ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLT = 5'd4;
  localparam logic [4:0] ALU_LUI = 5'd5;

  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

  state_t                r_state;
  state_t                w_next;
  logic [WW-1:0]         r_wait;
  logic                  r_illegal;
  logic                  r_bus_err;
  logic [PERF_CNT_W-1:0] r_cycle;
  logic [PERF_CNT_W-1:0] r_instret;

  logic w_is_r, w_r_alu, w_jr, w_lw, w_sw, w_beq, w_j, w_jal;
  logic w_addi, w_ori, w_lui, w_itype;
  logic [4:0] w_r_ctr, w_i_ctr;
  logic w_i_ext;

  assign w_is_r  = (op == 6'b000000);
  assign w_lw    = (op == 6'b100011);
  assign w_sw    = (op == 6'b101011);
  assign w_beq   = (op == 6'b000100);
  assign w_j     = (op == 6'b000010);
  assign w_jal   = (op == 6'b000011);
  assign w_addi  = (op == 6'b001000) | (op == 6'b001001);
  assign w_ori   = (op == 6'b001101);
  assign w_lui   = (op == 6'b001111);
  assign w_itype = w_addi | w_ori | w_lui;
  assign w_jr    = w_is_r & (funct == 6'b001000);

  always_comb begin
    w_r_alu = w_is_r;
    w_r_ctr = ALU_ADD;
    unique case (funct)
      6'b100000, 6'b100001: w_r_ctr = ALU_ADD;
      6'b100010, 6'b100011: w_r_ctr = ALU_SUB;
      6'b100100:            w_r_ctr = ALU_AND;
      6'b100101:            w_r_ctr = ALU_OR;
      6'b101010:            w_r_ctr = ALU_SLT;
      default:              w_r_alu = 1'b0;
    endcase
  end

  always_comb begin
    w_i_ctr = ALU_ADD;
    w_i_ext = 1'b1;
    unique case (1'b1)
      w_ori:   begin w_i_ctr = ALU_OR; w_i_ext = 1'b0; end
      w_lui:   w_i_ctr = ALU_LUI;
      default: w_i_ctr = ALU_ADD;
    endcase
  end

  logic w_mem_req, w_mem_we, w_ir_write, w_pc_write, w_pc_cond;
  logic w_reg_write, w_retire, w_set_ill, w_set_bus;

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_cond   = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    w_set_ill   = 1'b0;
    w_set_bus   = 1'b0;
    i_or_d      = 1'b0;
    pc_source   = 2'd0;
    reg_dst     = 2'd0;
    mem_to_reg  = 2'd0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    ext_op      = 1'b0;
    alu_ctr     = ALU_ADD;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculative branch target lands in ALUOut
        alu_src_b = 2'd3;
        ext_op    = 1'b1;
        unique case (1'b1)
          w_lw | w_sw:        w_next = S_MEM_ADDR;
          w_r_alu:            w_next = S_R_EXEC;
          w_jr | w_j | w_jal: w_next = S_JUMP;
          w_beq:              w_next = S_BRANCH;
          w_itype:            w_next = S_I_EXEC;
          default: begin
            w_set_ill = 1'b1;
            w_next    = S_FAULT;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_op    = 1'b1;
        w_next    = w_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_mem_req = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 2'd1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEM_WR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctr   = w_r_ctr;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        alu_src_a   = 1'b1;
        alu_ctr     = w_r_ctr;
        w_reg_write = 1'b1;
        reg_dst     = 2'd1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        ext_op    = w_i_ext;
        alu_ctr   = w_i_ctr;
        w_next    = S_I_WB;
      end
      S_I_WB: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        ext_op      = w_i_ext;
        alu_ctr     = w_i_ctr;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctr   = ALU_SUB;
        w_pc_cond = 1'b1;
        pc_source = 2'd1;
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        // PC already holds PC+4, so jal links straight from it
        w_pc_write = 1'b1;
        pc_source  = w_jr ? 2'd3 : 2'd2;
        if (w_jal) begin
          w_reg_write = 1'b1;
          reg_dst     = 2'd2;
          mem_to_reg  = 2'd2;
        end
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FETCH;
    endcase
    if (w_mem_req && !mem_ready && r_wait == WAIT_LAST) begin
      w_set_bus = 1'b1;
      w_next    = S_FAULT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_bus) r_bus_err <= 1'b1;
      if (w_mem_req && !mem_ready && w_next == r_state)
        r_wait <= r_wait + 1'b1;
      else
        r_wait <= '0;
      if (r_state != S_FAULT) r_cycle <= r_cycle + 1'b1;
      if (w_retire) r_instret <= r_instret + 1'b1;
    end
  end

  assign mem_req     = w_mem_req & ~reset;
  assign mem_we      = w_mem_we & ~reset;
  assign ir_write    = w_ir_write & ~reset;
  assign reg_write   = w_reg_write & ~reset;
  assign pc_en       = (w_pc_write | (w_pc_cond & zero)) & ~reset;
  assign state       = r_state;
  assign illegal     = r_illegal;
  assign bus_err     = r_bus_err;
  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Parametrised multi-cycle control unit for the next-generation MIPS core. Replaces the single-cycle decoder and the direct register-31 poke for jal.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath muxes, register file, PC and memory strobes.
- Memory accesses use a req/ready handshake with a wait-state timeout.
- Provides illegal-instruction and bus-error fault detection, plus cycle and retired-instruction counters.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive wait cycles with mem_req=1 and mem_ready=0 before a bus error.
- PERF_CNT_W, 32: width of cycle_cnt and instret_cnt.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- op  in  6  instruction[31:26], from IR
- funct  in  6  instruction[5:0], from IR
- zero  in  1  ALU equal flag
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write request (valid with mem_req)
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR
- pc_en  out  1  PC load = pc_write | (pc_write_cond & zero)
- pc_source  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],instr[25:0],2'b00}, 3=GPR[rs]
- reg_write  out  1  GPR write enable
- reg_dst  out  2  0=rt, 1=rd, 2=5'd31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- alu_src_a  out  1  0=PC, 1=GPR[rs]
- alu_src_b  out  2  0=GPR[rt], 1=4, 2=ext, 3=ext<<2
- ext_op  out  1  1=sign extend, 0=zero extend
- alu_ctr  out  5  ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5
- state  out  4  current state (debug)
- illegal  out  1  sticky: undefined op/funct decoded
- bus_err  out  1  sticky: memory timeout
- cycle_cnt  out  PERF_CNT_W  cycles since reset, wraps
- instret_cnt  out  PERF_CNT_W  retired instructions, wraps

Behaviour:
- Reset (asynchronous): state=FETCH(0); illegal, bus_err, both counters and the wait counter = 0. While reset is high, every strobe (mem_req, ir_write, pc_en, reg_write, mem_we) is 0. Releasing reset mid-instruction abandons that instruction.
- Outputs are Moore-decoded from state, except ir_write and pc_en in FETCH, which are qualified by mem_ready.
- State encodings: FETCH0, DECODE1, MEM_ADDR2, MEM_RD3, MEM_WB4, MEM_WR5, R_EXEC6, R_WB7, BRANCH8, JUMP9, I_EXEC10, I_WB11, FAULT12.
- FETCH:
  - Drives mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=1, ADD, pc_source=0.
  - On mem_ready: ir_write=1, pc_write=1, next state DECODE. Otherwise hold.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=3, ADD, ext_op=1 (branch target to ALUOut).
  - Dispatch: lw(100011)/sw(101011)->MEM_ADDR; R-type(000000) with funct add/addu/sub/subu/and/or/slt (100000/100001/100010/100011/100100/100101/101010)->R_EXEC; jr (funct 001000)->JUMP; beq(000100)->BRANCH; j(000010)/jal(000011)->JUMP; addi(001000)/addiu(001001)/ori(001101)/lui(001111)->I_EXEC.
  - Anything else: illegal<=1, next state FAULT.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD, ext_op=1; next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, i_or_d=1; on mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1; retire; next FETCH.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready retire and go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0; alu_ctr from funct (add/addu=ADD, sub/subu=SUB, and=AND, or=OR, slt=SLT); next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_ctr held; retire; next FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2. addi/addiu use ext_op=1, ADD; ori uses ext_op=0, OR; lui uses LUI. Next I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, controls held; retire; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_write_cond=1, pc_source=1; retire; next FETCH.
- JUMP: pc_write=1, with pc_source=3 for jr and 2 otherwise. jal additionally asserts reg_write=1, reg_dst=2, mem_to_reg=2; PC already holds PC+4 at this point. Retire; next FETCH.
- Latency at zero wait states: R/I-type 4 cycles, lw 5, sw 4, beq/j/jal/jr 3. Each wait cycle adds 1.
- Timeout:
  - The wait counter increments on each cycle with mem_req & ~mem_ready and clears on mem_ready or when leaving the state.
  - When the counter reaches MEM_TIMEOUT while mem_ready is still 0: bus_err<=1, next state FAULT. mem_ready arriving in the same cycle wins (no fault).
- FAULT: all strobes 0; held until reset. Counters freeze in FAULT.
- Counters:
  - cycle_cnt increments every non-reset cycle outside FAULT.
  - instret_cnt increments on the retire cycle.
  - Both wrap modulo 2^PERF_CNT_W.

Test Plan:
- addu (op 0, funct 100001), mem_ready tied 1 -> states 0,1,6,7,0; reg_write=1 with reg_dst=1 only in cycle 4; instret_cnt 0->1; cycle_cnt=4.
- lw, mem_ready low for 3 cycles in MEM_RD -> MEM_RD held for 4 cycles; total 8 cycles; reg_write with mem_to_reg=1 exactly once.
- beq with zero=1, then beq with zero=0 -> pc_en=1 in BRANCH for the first, 0 for the second; each takes 3 cycles.
- jal -> JUMP state asserts reg_write=1, reg_dst=2, mem_to_reg=2, pc_en=1, pc_source=2; jr -> pc_source=3, reg_write=0.
- op=111111 -> illegal=1, state=12, all strobes 0 for 10 following cycles. mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> bus_err=1 and state=12 after the 15th wait cycle; mem_ready arriving on the 15th cycle -> no fault.
- Assert reset asynchronously mid-MEM_WR -> strobes drop immediately; after release, state=0 and both counters=0.
